// File: rtl/hs_dest_arbiter.sv
// Destination side of a four-phase request/ack handshake shared by NUM_REQ sources.
// Requests are synchronized into clk_d, granted round-robin, and captured into one data register.
module hs_dest_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 0,
  localparam int GW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk_d,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        request,
  input  logic [NUM_REQ*DATA_W-1:0] d_in,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         data_out,
  output logic                      data_valid,
  output logic [GW-1:0]             grant_id,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_CAPTURE  = 2'd1;
  localparam logic [1:0] ST_WAIT_LOW = 2'd2;

  localparam int              TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]   TO_LAST  = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam int              IW       = GW + 1;
  localparam logic [IW-1:0]   IDX_LIM  = IW'(NUM_REQ);
  localparam logic [GW-1:0]   LAST_IDX = GW'(NUM_REQ - 1);

  function automatic logic [NUM_REQ-1:0] onehot(input logic [GW-1:0] idx);
    onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  logic [NUM_REQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_REQ-1:0] req_s;
  logic [DATA_W-1:0]  din_s [NUM_REQ];

  logic [1:0]         state_q, state_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [GW-1:0]      prio_q, prio_d;
  logic [NUM_REQ-1:0] mask_q, mask_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [DATA_W-1:0]  dout_q, dout_d;
  logic               dv_q, dv_d;
  logic               terr_q, terr_d;
  logic [TW-1:0]      cnt_q, cnt_d;

  logic [NUM_REQ-1:0] elig_s;
  logic               pick_vld_s;
  logic [GW-1:0]      pick_s;
  logic [IW-1:0]      idx_w;

  // Request synchronizer chains; only the last stage is ever looked at.
  always_ff @(posedge clk_d) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= {NUM_REQ{1'b0}};
      end
    end else begin
      sync_q[0] <= request;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  // Split the flat data bus into per-source slices.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      din_s[i] = d_in[i*DATA_W +: DATA_W];
    end
  end

  // Round-robin pick: scan from prio_q upward with wrap; lowest offset wins.
  always_comb begin
    elig_s     = req_s & ~mask_q;
    pick_vld_s = 1'b0;
    pick_s     = {GW{1'b0}};
    idx_w      = {IW{1'b0}};
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx_w = {1'b0, prio_q} + IW'(k);
      idx_w = (idx_w >= IDX_LIM) ? (idx_w - IDX_LIM) : idx_w;
      if (elig_s[idx_w[GW-1:0]]) begin
        pick_vld_s = 1'b1;
        pick_s     = idx_w[GW-1:0];
      end else begin
        pick_vld_s = pick_vld_s;
      end
    end
  end

  // Handshake FSM next-state logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    prio_d  = prio_q;
    ack_d   = ack_q;
    dout_d  = dout_q;
    cnt_d   = cnt_q;
    dv_d    = 1'b0;
    terr_d  = 1'b0;
    mask_d  = mask_q & req_s;
    case (state_q)
      ST_IDLE: begin
        ack_d = {NUM_REQ{1'b0}};
        if (pick_vld_s) begin
          grant_d = pick_s;
          prio_d  = (pick_s == LAST_IDX) ? {GW{1'b0}} : (pick_s + GW'(1'b1));
          state_d = ST_CAPTURE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        dout_d  = din_s[grant_q];
        dv_d    = 1'b1;
        ack_d   = onehot(grant_q);
        cnt_d   = {TW{1'b0}};
        state_d = ST_WAIT_LOW;
      end
      ST_WAIT_LOW: begin
        if (!req_s[grant_q]) begin
          ack_d   = {NUM_REQ{1'b0}};
          state_d = ST_IDLE;
        end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
          // Abandon a stuck source and hold it off until it deasserts.
          ack_d   = {NUM_REQ{1'b0}};
          terr_d  = 1'b1;
          mask_d  = mask_d | onehot(grant_q);
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + TW'(1'b1);
        end
      end
      default: begin
        ack_d   = {NUM_REQ{1'b0}};
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_d) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= {GW{1'b0}};
      prio_q  <= {GW{1'b0}};
      mask_q  <= {NUM_REQ{1'b0}};
      ack_q   <= {NUM_REQ{1'b0}};
      dout_q  <= {DATA_W{1'b0}};
      dv_q    <= 1'b0;
      terr_q  <= 1'b0;
      cnt_q   <= {TW{1'b0}};
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      prio_q  <= prio_d;
      mask_q  <= mask_d;
      ack_q   <= ack_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      terr_q  <= terr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ack         = ack_q;
  assign data_out    = dout_q;
  assign data_valid  = dv_q;
  assign grant_id    = grant_q;
  assign busy        = (state_q != ST_IDLE);
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_hs_dest_arbiter.sv
// Directed bench for hs_dest_arbiter: a per-cycle vector table plus hand-written handshake sequences.
module tb_hs_dest_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk_d = 1'b0;
  logic            rst;
  logic [N-1:0]    request;
  logic [N*DW-1:0] d_in;
  logic [N-1:0]    ack;
  logic [DW-1:0]   data_out;
  logic            data_valid;
  logic [1:0]      grant_id;
  logic            busy;
  logic            timeout_err;

  always #5 clk_d = ~clk_d;

  hs_dest_arbiter #(
    .NUM_REQ(N), .DATA_W(DW), .SYNC_STAGES(2), .TIMEOUT(8)
  ) dut (
    .clk_d(clk_d), .rst(rst), .request(request), .d_in(d_in),
    .ack(ack), .data_out(data_out), .data_valid(data_valid),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  typedef struct {
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] ack;
    logic [7:0]   dout;
    logic         dv;
    logic [1:0]   gid;
    logic         busy;
    logic         terr;
  } vec_t;

  vec_t       tbl [11];
  logic [7:0] exp_data [N];
  int         n_checks = 0;
  int         n_errors = 0;
  int         ack_viol = 0;
  int         got [8];
  int         got_n;

  function automatic vec_t mk(logic r, logic [N-1:0] q, logic [N-1:0] a, logic [7:0] d,
                              logic v, logic [1:0] g, logic b, logic t);
    vec_t x;
    x.rst = r; x.req = q; x.ack = a; x.dout = d; x.dv = v; x.gid = g; x.busy = b; x.terr = t;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [N-1:0] q);
    rst     = r;
    request = q;
    @(posedge clk_d);
    #1;
  endtask

  // Well-behaved sources: drop request on ack, re-raise once ack is low again.
  task automatic collect(input logic [N-1:0] active, input int n);
    logic [N-1:0] q;
    q     = active;
    got_n = 0;
    for (int c = 0; c < 400 && got_n < n; c++) begin
      step(1'b0, q);
      if (data_valid) begin
        got[got_n] = int'(grant_id);
        chk($sformatf("collect_data%0d", got_n), data_out, exp_data[grant_id]);
        got_n++;
      end
      for (int i = 0; i < N; i++) begin
        if (active[i]) begin
          if (ack[i]) q[i] = 1'b0;
          else if (!q[i]) q[i] = 1'b1;
        end
      end
    end
    chk("collect_count", got_n, n);
  endtask

  always @(negedge clk_d) begin
    if (($countones(ack) > 1) || (!busy && ack != '0)) ack_viol++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] q;
    int cnt, a3, seen, dvc, ac1;
    rst = 1'b1;
    request = '0;
    exp_data[0] = 8'h11; exp_data[1] = 8'h22; exp_data[2] = 8'hA5; exp_data[3] = 8'h44;
    d_in = {exp_data[3], exp_data[2], exp_data[1], exp_data[0]};

    tbl[0]  = mk(1'b1, 4'h0, 4'h0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b0, 4'h0, 4'h0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0);
    tbl[2]  = mk(1'b0, 4'h4, 4'h0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0);
    tbl[3]  = mk(1'b0, 4'h4, 4'h0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0);
    tbl[4]  = mk(1'b0, 4'h4, 4'h0, 8'h00, 1'b0, 2'd2, 1'b1, 1'b0);
    tbl[5]  = mk(1'b0, 4'h4, 4'h4, 8'hA5, 1'b1, 2'd2, 1'b1, 1'b0);
    tbl[6]  = mk(1'b0, 4'h4, 4'h4, 8'hA5, 1'b0, 2'd2, 1'b1, 1'b0);
    tbl[7]  = mk(1'b0, 4'h0, 4'h4, 8'hA5, 1'b0, 2'd2, 1'b1, 1'b0);
    tbl[8]  = mk(1'b0, 4'h0, 4'h4, 8'hA5, 1'b0, 2'd2, 1'b1, 1'b0);
    tbl[9]  = mk(1'b0, 4'h0, 4'h0, 8'hA5, 1'b0, 2'd2, 1'b0, 1'b0);
    tbl[10] = mk(1'b0, 4'h0, 4'h0, 8'hA5, 1'b0, 2'd2, 1'b0, 1'b0);

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].rst, tbl[i].req);
      chk($sformatf("v%0d_ack", i),  ack,         tbl[i].ack);
      chk($sformatf("v%0d_dout", i), data_out,    tbl[i].dout);
      chk($sformatf("v%0d_dv", i),   data_valid,  tbl[i].dv);
      chk($sformatf("v%0d_gid", i),  grant_id,    tbl[i].gid);
      chk($sformatf("v%0d_busy", i), busy,        tbl[i].busy);
      chk($sformatf("v%0d_terr", i), timeout_err, tbl[i].terr);
    end

    // All four requesting at once, each re-raising after its handshake.
    step(1'b1, 4'h0);
    step(1'b0, 4'h0);
    collect(4'hF, 5);
    for (int i = 0; i < 5; i++) chk($sformatf("rr_all_%0d", i), got[i], i % 4);

    // Source 1 re-requests right away while 3 is pending: 3 must still come first.
    step(1'b1, 4'h0);
    step(1'b0, 4'h0);
    collect(4'b1011, 6);
    chk("fair_0", got[0], 0); chk("fair_1", got[1], 1); chk("fair_2", got[2], 3);
    chk("fair_3", got[3], 0); chk("fair_4", got[4], 1); chk("fair_5", got[5], 3);

    // Reset in WAIT_REQ_LOW, then regrant from source-0 priority.
    step(1'b1, 4'h0);
    step(1'b0, 4'h0);
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      step(1'b0, 4'b0010);
      if (ack[1]) seen = 1;
    end
    chk("rst_mid_ack_seen", seen, 1);
    step(1'b1, 4'b1010);
    chk("rst_mid_ack", ack, 4'h0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_dout", data_out, 8'h00);
    chk("rst_mid_gid", grant_id, 2'd0);
    step(1'b0, 4'b1010);
    step(1'b0, 4'b1010);
    chk("rst_regrant_idle", busy, 1'b0);
    step(1'b0, 4'b1010);
    chk("rst_regrant_gid", grant_id, 2'd1);
    chk("rst_regrant_noack", ack, 4'h0);
    step(1'b0, 4'b1010);
    chk("rst_regrant_ack", ack, 4'b0010);
    chk("rst_regrant_dout", data_out, 8'h22);

    // Stuck source 3 times out after 8 ack cycles and is masked until it drops.
    step(1'b1, 4'h0);
    step(1'b0, 4'h0);
    q = 4'b1000;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      step(1'b0, q);
      if (ack[3]) seen = 1;
    end
    chk("to_ack_seen", seen, 1);
    cnt = 1;
    for (int c = 0; c < 30 && ack[3]; c++) begin
      step(1'b0, q);
      if (ack[3]) cnt++;
    end
    chk("to_ack_len", cnt, 8);
    chk("to_err_pulse", timeout_err, 1'b1);
    chk("to_busy", busy, 1'b0);
    step(1'b0, q);
    chk("to_err_clear", timeout_err, 1'b0);
    q = 4'b1001;
    seen = 0;
    a3 = 0;
    for (int c = 0; c < 40; c++) begin
      step(1'b0, q);
      if (ack[0]) begin seen = 1; q[0] = 1'b0; end
      if (ack[3]) a3++;
    end
    chk("to_other_served", seen, 1);
    chk("to_masked_no_ack", a3, 0);
    chk("to_masked_idle", busy, 1'b0);
    for (int c = 0; c < 4; c++) step(1'b0, 4'h0);
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      step(1'b0, 4'b1000);
      if (ack[3]) seen = c + 1;
    end
    chk("to_regrant_latency", seen, 4);
    for (int c = 0; c < 6; c++) step(1'b0, 4'h0);
    chk("to_regrant_done", busy, 1'b0);

    // One-cycle request pulse is still captured exactly once.
    step(1'b1, 4'h0);
    step(1'b0, 4'h0);
    step(1'b0, 4'b0010);
    dvc = 0;
    ac1 = 0;
    for (int c = 0; c < 12; c++) begin
      step(1'b0, 4'h0);
      if (data_valid) dvc++;
      if (ack[1]) ac1++;
    end
    chk("pulse_dv_count", dvc, 1);
    chk("pulse_ack_len", ac1, 1);
    chk("pulse_gid", grant_id, 2'd1);
    chk("pulse_dout", data_out, 8'h22);
    chk("pulse_idle", busy, 1'b0);

    chk("ack_exclusive", ack_viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hs_dest_arbiter.md
Name: hs_dest_arbiter

Overview:
- Destination-side controller for the four-phase request/ack handshake.
- Shares one destination data register among NUM_REQ source requesters using round-robin arbitration.
- Synchronizes each incoming request into the clk_d domain, captures the granted requester's data and drives that requester's ack.
- Recovers from a stuck handshake with an optional timeout.

Parameters:
- NUM_REQ, 4, number of source requesters (2..16).
- DATA_W, 8, data width per requester.
- SYNC_STAGES, 2, flops in each request synchronizer chain (>=2).
- TIMEOUT, 0, cycles in WAIT_REQ_LOW before forced abort; 0 disables the timeout.

Ports:
- clk_d  in  1  destination clock; single clock for the whole block.
- rst  in  1  synchronous, active-high reset.
- request  in  NUM_REQ  per-source request, asynchronous to clk_d.
- d_in  in  NUM_REQ*DATA_W  per-source data; slice i = d_in[i*DATA_W +: DATA_W]; stable while request[i] is high.
- ack  out  NUM_REQ  per-source acknowledge, registered.
- data_out  out  DATA_W  captured data, registered.
- data_valid  out  1  one-cycle pulse when data_out updates.
- grant_id  out  max(1,$clog2(NUM_REQ))  index of last/current granted source.
- busy  out  1  high whenever state != IDLE.
- timeout_err  out  1  one-cycle pulse on handshake abort.

Behaviour:
- Reset (rst high at clk_d edge):
  - ack=0, data_out=0, data_valid=0, grant_id=0, busy=0, timeout_err=0.
  - Synchronizer flops=0, state=IDLE, timeout counter=0, mask=0.
  - Round-robin pointer set so source 0 has highest priority first.
  - Reset mid-handshake drops ack on the same edge; no partial capture.
- Synchronization: req_s[i] is request[i] after SYNC_STAGES flops. All decisions use req_s only.
- Eligibility: eligible[i] = req_s[i] & ~mask[i].
- State IDLE:
  - If any eligible, pick the first eligible index scanning from (last_grant+1) mod NUM_REQ upward with wrap.
  - Register grant_id and go to CAPTURE. The pointer updates so the granted source becomes lowest priority next time.
  - If none eligible, stay in IDLE.
- State CAPTURE (exactly 1 cycle):
  - data_out <= d_in slice[grant_id]; data_valid <= 1 for one cycle; ack[grant_id] <= 1.
  - Go to WAIT_REQ_LOW and clear the timeout counter.
  - Capture happens even if req_s[grant_id] fell meanwhile.
- State WAIT_REQ_LOW:
  - Hold ack[grant_id]=1.
  - When req_s[grant_id]==0: ack <= 0, go to IDLE. The next grant is possible on the following IDLE edge, so ack has at least 1 low cycle between grants.
  - If TIMEOUT!=0 and counter reaches TIMEOUT-1 while req_s is still high: ack <= 0, timeout_err pulse, set mask[grant_id], go to IDLE.
- Mask: mask[i] clears when req_s[i]==0, so a stuck source is not regranted until it deasserts.
- Only one ack bit is ever high. ack is never high in IDLE or in the cycle after reset.
- Latency: the first edge where req_s is high and the state is IDLE grants the source. data_valid and ack rise on the next edge (2 edges after req_s is seen). Request pin to ack is SYNC_STAGES+2 edges.
- Simultaneous requests: exactly one grant per handshake; the others wait in IDLE ordering.
- Requests arriving during a handshake are held pending and do not disturb the current grant.
- grant_id holds its value between handshakes.

Test Plan:
- Reset, then request[2] high with d_in slice2=0xA5, SYNC_STAGES=2 -> ack[2] rises 4 edges after request, data_out=0xA5, data_valid 1 cycle. Drop request -> ack[2] low SYNC_STAGES+1 edges later.
- request[0..3] all high simultaneously, each source completing its handshake and re-raising request -> grant order 0,1,2,3,0; never two ack bits high.
- Source 1 re-requests immediately while source 3 is pending -> source 3 is served before source 1 again (round-robin fairness).
- rst asserted while ack[1]=1 in WAIT_REQ_LOW -> next edge: ack=0, busy=0, data_out=0. Request still high after reset -> regranted with source 0 priority order.
- TIMEOUT=8, request[3] held high forever -> ack[3] high 8 cycles then low, timeout_err pulse. Source 3 is not regranted while high; other sources are still served. After request[3] drops and re-rises, it is granted normally.
- request[1] pulse of 1 cycle shorter than the sync path -> captured once, ack[1] high for exactly 1 cycle after CAPTURE, then return to IDLE.
